// File: rtl/toggle_hs_pkg.sv
// Shared types and defaults for the toggle-handshake responder.
// Buffer occupancy encoding, default parameters and the parity helper.
package toggle_hs_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 16;

    // Even parity bit for a word zero-extended to 64 bits.
    function automatic logic even_par(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/toggle_hs_responder_sync.sv
// Toggle synchronizer + edge detector: SYNC_STAGES flop chain, last-seen level
// register and a pending flag. Reusable on the transmitter side for ack_tgl.
module toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic tgl_i,
    input  logic take_i,
    output logic tgl_s_o,
    output logic pending_o
);

    logic seen_q;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign tgl_s_o = tgl_i;
        end else begin : g_chain
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= tgl_i;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign tgl_s_o = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // The consumer decides when an offer is taken; only then is the level retired.
    always_ff @(posedge clk) begin
        if (reset)       seen_q <= 1'b0;
        else if (take_i) seen_q <= tgl_s_o;
    end

    assign pending_o = tgl_s_o ^ seen_q;

endmodule

// File: rtl/toggle_hs_responder.sv
// Receiving end of a two-phase toggle handshake with a 2-entry output buffer.
// Optional TOGGLE_HS_PARITY_EN adds req_par/par_err and drops bad-parity words.
module toggle_hs_responder
    import toggle_hs_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_tgl,
    input  logic [WIDTH-1:0] req_data,
`ifdef TOGGLE_HS_PARITY_EN
    input  logic             req_par,
    output logic             par_err,
`endif
    output logic             ack_tgl,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             stall,
    output logic [CNT_W-1:0] event_count
);

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             ack_q, ack_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending, req_s;
    logic             take, wr, pop, par_ok;

    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .tgl_i    (req_tgl),
        .take_i   (take),
        .tgl_s_o  (req_s),
        .pending_o(pending)
    );

`ifdef TOGGLE_HS_PARITY_EN
    logic par_err_q;
    assign par_ok  = (even_par(64'(req_data)) == req_par);
    assign par_err = par_err_q;
    always_ff @(posedge clk) begin
        if (reset) par_err_q <= 1'b0;
        else       par_err_q <= take && !par_ok;
    end
`else
    assign par_ok = 1'b1;
`endif

    // Capture looks at registered occupancy only: a same-edge pop never frees FULL.
    assign take = pending && (state_q != ST_FULL);
    assign wr   = take && par_ok;
    assign pop  = (state_q != ST_EMPTY) && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        ack_d   = ack_q;
        cnt_d   = cnt_q;
        if (take) ack_d = ~ack_q;
        if (wr)   cnt_d = cnt_q + CNT_W'(1);
        case (state_q)
            ST_EMPTY: begin
                if (wr) begin
                    head_d  = req_data;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (wr && pop) begin
                    head_d = req_data;
                end else if (wr) begin
                    tail_d  = req_data;
                    state_d = ST_FULL;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            ack_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ack_q   <= ack_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ack_tgl     = ack_q;
    assign out_valid   = (state_q != ST_EMPTY);
    assign out_data    = head_q;
    assign stall       = pending && (state_q == ST_FULL);
    assign event_count = cnt_q;

endmodule

// File: tb/tb_toggle_hs_responder.sv
// Scoreboard bench for toggle_hs_responder: directed offers push expected words,
// a negedge monitor pops and compares on every out_valid && out_ready.
module tb_toggle_hs_responder;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_tgl;
    logic [W-1:0]  req_data;
    logic          ack_tgl;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic          stall;
    logic [CW-1:0] event_count;
`ifdef TOGGLE_HS_PARITY_EN
    logic          req_par;
    logic          par_err;
`endif

    int            n_tests = 0;
    int            n_fail  = 0;
    int            n_pop   = 0;
    logic [W-1:0]  expq[$];
    logic [CW-1:0] exp_cnt;
    logic          exp_ack;

    toggle_hs_responder #(.WIDTH(W), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_tgl    (req_tgl),
        .req_data   (req_data),
`ifdef TOGGLE_HS_PARITY_EN
        .req_par    (req_par),
        .par_err    (par_err),
`endif
        .ack_tgl    (ack_tgl),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .stall      (stall),
        .event_count(event_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic good);
        req_data = d;
`ifdef TOGGLE_HS_PARITY_EN
        req_par = good ? ^d : ~(^d);
`endif
        req_tgl = ~req_tgl;
        exp_ack = ~exp_ack;
        if (good) begin
            expq.push_back(d);
            exp_cnt++;
        end
    endtask

    task automatic wait_ack();
        for (int k = 0; k < 12 && ack_tgl !== exp_ack; k++) step();
        check("ack_wait", 32'(ack_tgl), 32'(exp_ack));
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_pop++;
            if (expq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_unexpected: got %0h with empty scoreboard", out_data);
            end else begin
                check("pop_data", 32'(out_data), 32'(expq.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic          ack_hold;
        logic [CW-1:0] cnt_hold;
        int            pop_base;

        reset = 1'b1; req_tgl = 1'b0; req_data = '0; out_ready = 1'b0;
`ifdef TOGGLE_HS_PARITY_EN
        req_par = 1'b0;
`endif
        exp_ack = 1'b0; exp_cnt = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_ack",   32'(ack_tgl),   32'(0));
        check("rst_cnt",   32'(event_count), 32'(0));
        check("rst_stall", 32'(stall),     32'(0));
        check("rst_data",  32'(out_data),  32'(0));

        // single word: capture 3 edges after the flip
        out_ready = 1'b1;
        send(8'hA5, 1'b1);
        step(); check("lat_e1_ack", 32'(ack_tgl), 32'(0));
        step(); check("lat_e2_ack", 32'(ack_tgl), 32'(0));
        check("lat_e2_valid", 32'(out_valid), 32'(0));
        step(); check("lat_e3_ack", 32'(ack_tgl), 32'(1));
        check("lat_e3_valid", 32'(out_valid), 32'(1));
        check("lat_e3_data",  32'(out_data),  32'(8'hA5));
        check("lat_e3_cnt",   32'(event_count), 32'(1));
        step(); check("single_drained", 32'(out_valid), 32'(0));

        // back-pressure
        out_ready = 1'b0;
        send(8'h01, 1'b1); wait_ack();
        send(8'h02, 1'b1); wait_ack();
        check("full_valid", 32'(out_valid), 32'(1));
        check("full_head",  32'(out_data),  32'(8'h01));
        check("full_nostall", 32'(stall),   32'(0));
        ack_hold = exp_ack; cnt_hold = exp_cnt;
        send(8'h03, 1'b1);
        repeat (3) step();
        check("bp_stall",    32'(stall),       32'(1));
        check("bp_ack_hold", 32'(ack_tgl),     32'(ack_hold));
        check("bp_cnt_hold", 32'(event_count), 32'(cnt_hold));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_pop_stall", 32'(stall),   32'(0));
        check("bp_pop_ack",   32'(ack_tgl), 32'(ack_hold));
        check("bp_pop_head",  32'(out_data), 32'(8'h02));
        step();
        check("bp_cap_ack", 32'(ack_tgl),     32'(exp_ack));
        check("bp_cap_cnt", 32'(event_count), 32'(exp_cnt));
        check("bp_cap_head", 32'(out_data),   32'(8'h02));
        out_ready = 1'b1;
        step(); step();
        out_ready = 1'b0;
        check("bp_drained", 32'(out_valid), 32'(0));

        // capture and pop on the same edge while ONE
        send(8'h10, 1'b1); wait_ack();
        check("one_head", 32'(out_data), 32'(8'h10));
        send(8'h11, 1'b1);
        step(); step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("cp_valid", 32'(out_valid),   32'(1));
        check("cp_head",  32'(out_data),    32'(8'h11));
        check("cp_cnt",   32'(event_count), 32'(exp_cnt));
        check("cp_ack",   32'(ack_tgl),     32'(exp_ack));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("cp_was_one", 32'(out_valid), 32'(0));

        // reset while FULL with a pending offer at req_tgl=1
        send(8'h20, 1'b1); wait_ack();
        send(8'h21, 1'b1); wait_ack();
        send(8'h22, 1'b1);
        repeat (3) step();
        check("pre_rst_stall", 32'(stall), 32'(1));
        check("pre_rst_tgl",   32'(req_tgl), 32'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        expq.delete();
        exp_cnt = '0; exp_ack = 1'b0;
        check("mid_rst_valid", 32'(out_valid),   32'(0));
        check("mid_rst_ack",   32'(ack_tgl),     32'(0));
        check("mid_rst_cnt",   32'(event_count), 32'(0));
        expq.push_back(8'h22); exp_cnt = 1; exp_ack = 1'b1;
        step(); check("rr_e1_ack", 32'(ack_tgl), 32'(0));
        step(); check("rr_e2_ack", 32'(ack_tgl), 32'(0));
        step(); check("rr_e3_ack", 32'(ack_tgl), 32'(1));
        check("rr_e3_data", 32'(out_data),    32'(8'h22));
        check("rr_e3_cnt",  32'(event_count), 32'(1));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("rr_drained", 32'(out_valid), 32'(0));

        // counter wrap: 17 words with a 4-bit counter
        reset = 1'b1; req_tgl = 1'b0;
        step();
        reset = 1'b0;
        expq.delete();
        exp_cnt = '0; exp_ack = 1'b0;
        pop_base = n_pop;
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            send(8'h40 + 8'(i), 1'b1);
            wait_ack();
        end
        repeat (3) step();
        out_ready = 1'b0;
        check("wrap_cnt",   32'(event_count), 32'(1));
        check("wrap_words", 32'(n_pop - pop_base), 32'(17));

`ifdef TOGGLE_HS_PARITY_EN
        cnt_hold = exp_cnt;
        send(8'h03, 1'b0); wait_ack();
        check("par_err_hi",  32'(par_err),     32'(1));
        check("par_novalid", 32'(out_valid),   32'(0));
        check("par_cnt",     32'(event_count), 32'(cnt_hold));
        step();
        check("par_err_lo", 32'(par_err), 32'(0));
        send(8'h5A, 1'b1); wait_ack();
        check("par_ok_err",  32'(par_err),     32'(0));
        check("par_ok_data", 32'(out_data),    32'(8'h5A));
        check("par_ok_cnt",  32'(event_count), 32'(exp_cnt));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
`endif

        step();
        check("queue_drained", 32'(expq.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
